// File: rtl/morse_entry_controller.sv
// Morse word entry sequencer: edge-detects the entry switches, packs symbols two bits each,
// offers the word to the checker and shows its verdict. Optional macro: MORSE_WAIT_TIMEOUT_EN.
module morse_entry_controller #(
    parameter int MAX_SYMS      = 16,
    parameter int RESULT_CYCLES = 50_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sw_dash,
    input  logic                          sw_dot,
    input  logic                          sw_space,
    input  logic                          sw_done,
    input  logic                          chk_ready,
    input  logic                          chk_valid,
    input  logic                          chk_correct,
    output logic [2*MAX_SYMS-1:0]         morse_word,
    output logic [$clog2(MAX_SYMS+1)-1:0] sym_count,
    output logic                          word_valid,
    output logic [2:0]                    disp_mode,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(MAX_SYMS + 1);
    localparam int TMR_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(MAX_SYMS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESULT_CYCLES - 1);

    localparam logic [2:0] DISP_BLANK  = 3'd0;
    localparam logic [2:0] DISP_DASH   = 3'd1;
    localparam logic [2:0] DISP_DOT    = 3'd2;
    localparam logic [2:0] DISP_YELLOW = 3'd3;
    localparam logic [2:0] DISP_GREEN  = 3'd4;
    localparam logic [2:0] DISP_RED    = 3'd5;

    typedef enum logic [1:0] {ENTRY, SUBMIT, WAIT_RES, SHOW} state_t;

    state_t                  state, state_n;
    logic [2*MAX_SYMS-1:0]   word_n;
    logic [CNT_W-1:0]        count_n;
    logic                    valid_n;
    logic [2:0]              disp_n;
    logic                    ovf_n;
    logic [TMR_W-1:0]        timer, timer_n;

    // Switch vector order: {done, space, dot, dash}
    logic [3:0] sw_cur, sw_prev, edges;
    logic       one_edge;
    logic [1:0] sym_code;
    logic [2:0] sym_disp;

    assign sw_cur   = {sw_done, sw_space, sw_dot, sw_dash};
    assign edges    = sw_cur & ~sw_prev;
    assign one_edge = $onehot(edges);

    always_comb begin
        sym_code = 2'b00;
        sym_disp = DISP_DOT;
        if (edges[0]) begin
            sym_code = 2'b01;
            sym_disp = DISP_DASH;
        end else if (edges[2]) begin
            sym_code = 2'b10;
            sym_disp = DISP_BLANK;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = morse_word;
        count_n = sym_count;
        valid_n = word_valid;
        disp_n  = disp_mode;
        ovf_n   = overflow;
        timer_n = timer;
        case (state)
            ENTRY: begin
                if (one_edge && edges[3]) begin
                    if (sym_count != '0) begin
                        if (sym_count < FULL) begin
                            word_n  = {morse_word[2*MAX_SYMS-3:0], 2'b11};
                            count_n = sym_count + CNT_W'(1);
                        end else begin
                            ovf_n = 1'b1;
                        end
                        valid_n = 1'b1;
                        disp_n  = DISP_YELLOW;
                        state_n = SUBMIT;
                    end
                end else if (one_edge) begin
                    if (sym_count < FULL) begin
                        word_n  = {morse_word[2*MAX_SYMS-3:0], sym_code};
                        count_n = sym_count + CNT_W'(1);
                        disp_n  = sym_disp;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            SUBMIT: begin
                disp_n = DISP_YELLOW;
                if (chk_ready) begin
                    valid_n = 1'b0;
                    state_n = WAIT_RES;
`ifdef MORSE_WAIT_TIMEOUT_EN
                    timer_n = TMR_LOAD;
`endif
                end
            end
            WAIT_RES: begin
                disp_n = DISP_YELLOW;
                if (chk_valid) begin
                    disp_n  = chk_correct ? DISP_GREEN : DISP_RED;
                    timer_n = TMR_LOAD;
                    state_n = SHOW;
`ifdef MORSE_WAIT_TIMEOUT_EN
                end else if (timer == '0) begin
                    // No verdict in time: treat the word as wrong
                    disp_n  = DISP_RED;
                    timer_n = TMR_LOAD;
                    state_n = SHOW;
                end else begin
                    timer_n = timer - TMR_W'(1);
`endif
                end
            end
            SHOW: begin
                if (timer == '0) begin
                    word_n  = '0;
                    count_n = '0;
                    ovf_n   = 1'b0;
                    disp_n  = DISP_BLANK;
                    state_n = ENTRY;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: begin
                state_n = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ENTRY;
            morse_word <= '0;
            sym_count  <= '0;
            word_valid <= 1'b0;
            disp_mode  <= DISP_BLANK;
            overflow   <= 1'b0;
            timer      <= '0;
            sw_prev    <= '0;
        end else begin
            state      <= state_n;
            morse_word <= word_n;
            sym_count  <= count_n;
            word_valid <= valid_n;
            disp_mode  <= disp_n;
            overflow   <= ovf_n;
            timer      <= timer_n;
            sw_prev    <= sw_cur;
        end
    end

endmodule

// File: doc/morse_entry_controller.md
Name: morse_entry_controller

Overview:
- Sequences Morse word entry from the four entry switches (dash, dot, space, done).
- Packs the symbols into a 2-bit-per-symbol word and hands the finished word to the keyboard checker over a valid/ready handshake.
- Waits for the checker's verdict, then drives a registered display-mode code. The VGA colour logic decodes this code to draw rectangle, square, blank, yellow, green or red.

Parameters:
- MAX_SYMS, 16, maximum symbols per word, including the done terminator.
- RESULT_CYCLES, 50_000_000, number of clk cycles the green/red verdict is shown before entry restarts. Must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sw_dash  in  1  dash switch level, already synchronised to clk.
- sw_dot  in  1  dot switch level, already synchronised to clk.
- sw_space  in  1  letter-gap switch level, already synchronised to clk.
- sw_done  in  1  end-of-word switch level, already synchronised to clk.
- chk_ready  in  1  checker can accept a word.
- chk_valid  in  1  one-cycle pulse: verdict available.
- chk_correct  in  1  verdict; sampled only when chk_valid=1.
- morse_word  out  2*MAX_SYMS  packed symbols; newest symbol in bits [1:0].
- sym_count  out  $clog2(MAX_SYMS+1)  number of symbols stored.
- word_valid  out  1  word offered to checker.
- disp_mode  out  3  display code: 0 BLANK, 1 DASH, 2 DOT, 3 YELLOW, 4 GREEN, 5 RED.
- overflow  out  1  sticky flag: a symbol was dropped because the word was full.

Behaviour:
- Reset (asynchronous):
  - state ENTRY; morse_word=0, sym_count=0, word_valid=0, disp_mode=BLANK, overflow=0.
  - Internal previous-switch registers cleared to 0, so a switch already high when reset releases registers as an edge.
- Edge detect:
  - Each switch has a registered previous value; an edge is cur=1 while prev=0.
  - If more than one edge occurs in the same cycle, all of them are ignored.
- Symbol codes: dash=01, dot=00, space=10, done=11.
- Append operation: morse_word <= {morse_word[2*MAX_SYMS-3:0], code}; sym_count+1.
- Latency: an edge sampled in cycle N updates morse_word, sym_count and disp_mode at the clk edge ending cycle N.
- State ENTRY:
  - dash/dot/space edge, sym_count<MAX_SYMS: append. disp_mode becomes DASH, DOT or BLANK respectively.
  - dash/dot/space edge, sym_count==MAX_SYMS: word unchanged; overflow<=1.
  - done edge with sym_count==0: ignored.
  - done edge with sym_count<MAX_SYMS: append 11, go to SUBMIT, word_valid<=1.
  - done edge with sym_count==MAX_SYMS: no append; overflow<=1; go to SUBMIT, word_valid<=1.
- State SUBMIT:
  - word_valid stays 1; morse_word and sym_count stay frozen.
  - Transfer happens on a cycle where word_valid & chk_ready; then word_valid<=0 and go to WAIT_RES.
  - chk_ready may be high on the cycle SUBMIT is entered; transfer then completes in one cycle.
  - disp_mode=YELLOW.
- State WAIT_RES:
  - disp_mode=YELLOW.
  - On chk_valid: disp_mode<=GREEN if chk_correct, else RED; load timer with RESULT_CYCLES-1; go to SHOW.
  - chk_valid arriving in any other state is ignored.
- State SHOW:
  - Timer decrements each cycle.
  - When timer==0: go to ENTRY; clear morse_word, sym_count and overflow; disp_mode<=BLANK.
  - The verdict is visible for exactly RESULT_CYCLES cycles.
- Switch edges in SUBMIT, WAIT_RES and SHOW are ignored. Prev registers still track the switch levels, so a switch held through SHOW does not create an edge on return to ENTRY.
- Reset asserted mid-operation (any state) returns all outputs to reset values immediately; any pending handshake is abandoned.
- Unused disp_mode codes 6 and 7 are never driven.

Optional Feature:
- Macro: MORSE_WAIT_TIMEOUT_EN.
- Defined: the timer is also loaded with RESULT_CYCLES-1 on entry to WAIT_RES. If it reaches 0 with no chk_valid, the verdict is forced wrong: disp_mode<=RED, timer reloaded, go to SHOW.
  - chk_valid in the same cycle as timeout wins.
- Not defined: WAIT_RES waits indefinitely for chk_valid.

Test Plan (bench uses MAX_SYMS=4, RESULT_CYCLES=8):
- Pulse dash, dot, done, chk_ready=1 → morse_word=8'b00_01_00_11, sym_count=3, word_valid high for exactly 1 cycle. disp_mode sequence DASH, DOT, YELLOW.
- Then pulse chk_valid=1, chk_correct=1 → disp_mode=GREEN for 8 cycles, then BLANK; morse_word=0, sym_count=0.
- Pulse 5 dots then done with chk_ready=0 for 10 cycles → sym_count=4, overflow=1, word_valid held 10 cycles and morse_word frozen. Drop after chk_ready=1.
- dash and dot rising in the same cycle, then done with sym_count=0 → no change, state remains ENTRY, word_valid=0.
- Assert reset during WAIT_RES → word_valid=0, disp_mode=BLANK, sym_count=0 asynchronously. A later chk_valid has no effect.
- With MORSE_WAIT_TIMEOUT_EN defined: submit a word, never pulse chk_valid → RED after 8 cycles in WAIT_RES, then BLANK after 8 more.
